// File: rtl/div_seq_controller.sv
// Control FSM for a WIDTH-iteration shift/subtract restoring divider with start/valid/ack handshake.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor jumps from LOAD straight to DONE with dz_err set.
module div_seq_controller #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic             divisor_zero,
    input  logic             ack,
    output logic             load,
    output logic             shift,
    output logic             add,
    output logic             inbit,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             valid,
    output logic             dz_err,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        TEST    = 3'd2,
        RESTORE = 3'd3,
        ACCEPT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state;
    state_t nxt;
    logic   last_iter;

    assign last_iter = (iter == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_CHECK_EN
    logic zero_skip;
    assign zero_skip = divisor_zero;
`else
    logic zero_skip;
    logic unused_divisor_zero;
    assign zero_skip           = 1'b0;
    assign unused_divisor_zero = divisor_zero;
`endif

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = zero_skip ? DONE : TEST;
            TEST:    nxt = sign ? RESTORE : ACCEPT;
            RESTORE: nxt = last_iter ? DONE : TEST;
            ACCEPT:  nxt = last_iter ? DONE : TEST;
            DONE: begin
                if (!ack)       nxt = DONE;
                else if (start) nxt = LOAD;
                else            nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            load   <= 1'b0;
            shift  <= 1'b0;
            add    <= 1'b0;
            inbit  <= 1'b0;
            sel    <= 2'b00;
            busy   <= 1'b0;
            valid  <= 1'b0;
            dz_err <= 1'b0;
            iter   <= '0;
        end else begin
            state <= nxt;
            load  <= (nxt == LOAD);
            shift <= (nxt == LOAD) || (nxt == RESTORE) || (nxt == ACCEPT);
            add   <= (nxt == RESTORE);
            inbit <= (nxt == ACCEPT);
            busy  <= (nxt != IDLE) && (nxt != DONE);
            valid <= (nxt == DONE);
            case (nxt)
                LOAD:         sel <= 2'b10;
                TEST,RESTORE: sel <= 2'b01;
                ACCEPT:       sel <= 2'b11;
                default:      sel <= 2'b00;
            endcase
            if (nxt == LOAD)
                iter <= '0;
            else if (state == RESTORE || state == ACCEPT)
                iter <= iter + 1'b1;
            if (state == LOAD)
                dz_err <= zero_skip;
            else if (nxt != DONE)
                dz_err <= 1'b0;
`ifndef SYNTHESIS
            if (!(state inside {IDLE, LOAD, TEST, RESTORE, ACCEPT, DONE}))
                $display("div_seq_controller: illegal state encoding %0d, returning to IDLE", state);
`endif
        end
    end

endmodule

// File: tb/tb_div_seq_controller.sv
// Directed bench for div_seq_controller (WIDTH=8): table of whole operations plus reset and divide-by-zero sequences.
module tb_div_seq_controller;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             sign = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             ack = 1'b0;
    logic             load, shift, add, inbit, busy, valid, dz_err;
    logic [1:0]       sel;
    logic [CNT_W-1:0] iter;

    int checks = 0;
    int errors = 0;

    div_seq_controller #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .sign(sign),
        .divisor_zero(divisor_zero), .ack(ack), .load(load), .shift(shift),
        .add(add), .inbit(inbit), .sel(sel), .busy(busy), .valid(valid),
        .dz_err(dz_err), .iter(iter)
    );

    always #5 clk = ~clk;

    // {load, sel, shift, inbit, add, busy, valid}
    function automatic logic [7:0] ctl();
        return {load, sel, shift, inbit, add, busy, valid};
    endfunction

    localparam logic [7:0] CTL_IDLE = 8'h00;
    localparam logic [7:0] CTL_LOAD = 8'hD2;
    localparam logic [7:0] CTL_TEST = 8'h22;
    localparam logic [7:0] CTL_DONE = 8'h01;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one operation from the negedge before edge 0; returns observations.
    task automatic run_op(input logic [7:0] signs, input bit dz, input bit mid_start,
                          input int ack_delay, input bit ack_start,
                          output int vcyc, output logic [7:0] q, output int nadd,
                          output int nbusy, output int iterv, output int dzv,
                          output logic [7:0] c1, output logic [7:0] c2,
                          output bit held_ok, output logic [7:0] post, output int post_iter);
        int k;
        vcyc = -1; q = '0; nadd = 0; nbusy = 0; iterv = -1; dzv = -1;
        c1 = '0; c2 = '0; held_ok = 1'b1; post = '1; post_iter = -1; k = 0;
        start = 1'b1; divisor_zero = dz; ack = 1'b0;
        step();
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc == 1) c1 = ctl();
            if (cyc == 2) c2 = ctl();
            if (valid) begin
                vcyc = cyc; iterv = int'(iter); dzv = int'(dz_err);
                break;
            end
            if (busy) nbusy++;
            if (shift && !load) begin
                q = {q[6:0], inbit};
                if (add) nadd++;
            end
            start = mid_start && (cyc == 6);
            ack   = mid_start;
            if (sel == 2'b01 && !shift && k < 8) begin
                sign = signs[7-k];
                k++;
            end else begin
                sign = 1'($urandom_range(0, 1));
            end
            step();
        end
        start = 1'b0; ack = 1'b0;
        if (vcyc > 0) begin
            for (int d = 0; d < ack_delay; d++) begin
                if (!(valid && ctl() == CTL_DONE && int'(iter) == iterv)) held_ok = 1'b0;
                step();
            end
            ack = 1'b1; start = ack_start;
            step();
            post = ctl(); post_iter = int'(iter);
            ack = 1'b0; start = 1'b0;
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] signs;
        bit         mid_start;
        int         ack_delay;
        bit         ack_start;
        logic [7:0] exp_q;
        int         exp_add;
    } vec_t;

    vec_t vecs[4];

    int         vcyc, nadd, nbusy, iterv, dzv, post_iter;
    logic [7:0] q, c1, c2, post;
    bit         held_ok;

    initial begin
        // 13/3: quotient 00000100 -> only iteration 6 accepts
        vecs[0] = '{"div13by3",    8'b11111011, 1'b0, 0, 1'b0, 8'b00000100, 7};
        vecs[1] = '{"allrestore",  8'b11111111, 1'b0, 0, 1'b0, 8'b00000000, 8};
        vecs[2] = '{"midstart",    8'b00000000, 1'b1, 0, 1'b0, 8'b11111111, 0};
        vecs[3] = '{"ackhold",     8'b10101010, 1'b0, 5, 1'b1, 8'b01010101, 4};

        @(negedge clk);
        chk("reset_ctl", int'(ctl()), int'(CTL_IDLE));
        chk("reset_iter", int'(iter), 0);
        chk("reset_dz", int'(dz_err), 0);
        step();
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_op(vecs[i].signs, 1'b0, vecs[i].mid_start, vecs[i].ack_delay, vecs[i].ack_start,
                   vcyc, q, nadd, nbusy, iterv, dzv, c1, c2, held_ok, post, post_iter);
            chk({vecs[i].name, "_load_ctl"}, int'(c1), int'(CTL_LOAD));
            chk({vecs[i].name, "_test_ctl"}, int'(c2), int'(CTL_TEST));
            chk({vecs[i].name, "_valid_cycle"}, vcyc, 18);
            chk({vecs[i].name, "_quotient"}, int'(q), int'(vecs[i].exp_q));
            chk({vecs[i].name, "_adds"}, nadd, vecs[i].exp_add);
            chk({vecs[i].name, "_busy_cycles"}, nbusy, 17);
            chk({vecs[i].name, "_iter_done"}, iterv, 8);
            chk({vecs[i].name, "_dz_err"}, dzv, 0);
            if (vecs[i].ack_delay > 0) chk({vecs[i].name, "_held"}, int'(held_ok), 1);
            if (vecs[i].ack_start) begin
                chk({vecs[i].name, "_restart_ctl"}, int'(post), int'(CTL_LOAD));
            end else begin
                chk({vecs[i].name, "_post_ctl"}, int'(post), int'(CTL_IDLE));
                chk({vecs[i].name, "_post_iter"}, post_iter, 8);
            end
        end

        // DUT is now in cycle 1 (LOAD) of a new run; reset it at cycle 9.
        for (int c = 1; c < 9; c++) begin
            sign = 1'($urandom_range(0, 1));
            step();
        end
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        chk("midreset_ctl", int'(ctl()), int'(CTL_IDLE));
        chk("midreset_iter", int'(iter), 0);
        reset = 1'b0;
        step();
        run_op(8'b11111011, 1'b0, 1'b0, 0, 1'b0, vcyc, q, nadd, nbusy, iterv, dzv,
               c1, c2, held_ok, post, post_iter);
        chk("after_reset_valid_cycle", vcyc, 18);
        chk("after_reset_quotient", int'(q), 4);

        run_op(8'b00001111, 1'b1, 1'b0, 2, 1'b0, vcyc, q, nadd, nbusy, iterv, dzv,
               c1, c2, held_ok, post, post_iter);
`ifdef DIV_ZERO_CHECK_EN
        chk("dz_valid_cycle", vcyc, 2);
        chk("dz_iter", iterv, 0);
        chk("dz_flag", dzv, 1);
        chk("dz_held", int'(held_ok), 1);
        chk("dz_post_ctl", int'(post), int'(CTL_IDLE));
        chk("dz_clear", int'(dz_err), 0);
`else
        chk("dz_valid_cycle", vcyc, 18);
        chk("dz_iter", iterv, 8);
        chk("dz_flag", dzv, 0);
        chk("dz_quotient", int'(q), 8'hF0);
        chk("dz_post_ctl", int'(post), int'(CTL_IDLE));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
